// File: rtl/conv_frame_loader_pkg.sv
// Shared definitions for the convolution frame loader and the conv_complex benches:
// loader state encoding, kernel tap count and the Q-format word-width helper.
package conv_frame_loader_pkg;

  typedef enum logic [1:0] {
    LOAD_K    = 2'd0,
    LOAD_S    = 2'd1,
    RUN       = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  localparam int NUM_TAPS = 3;

  function automatic int calc_w(input int qi, input int qf);
    return qi + qf;
  endfunction

endpackage

// File: rtl/cplx_pack_reg.sv
// Indexed bank of N complex words, each stored as {re, im}, packed into one flat bus.
// MSB_FIRST places word 0 in the top slot; otherwise word 0 sits in the LSBs.
module cplx_pack_reg #(
  parameter int W         = 8,
  parameter int N         = 3,
  parameter bit MSB_FIRST = 1'b0,
  parameter int IW        = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_idx,
  input  logic [W-1:0]      re,
  input  logic [W-1:0]      im,
  output logic [2*W*N-1:0]  data
);

  logic [N-1:0][2*W-1:0] mem;
  logic [IW-1:0]         slot;

  always_comb begin
    slot = MSB_FIRST ? (IW'(N - 1) - wr_idx) : wr_idx;
  end

  // Only the addressed word changes, and only on its own write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[slot] <= {re, im};
    end
  end

  assign data = mem;

endmodule

// File: rtl/conv_frame_loader.sv
// Streams a 3-tap complex kernel and a NUM_ELEMS-sample complex signal into packed
// registers, then runs one conv_complex pass and reports completion and overflow.
module conv_frame_loader
  import conv_frame_loader_pkg::*;
#(
  parameter int  QI        = 4,
  parameter int  QF        = 4,
  parameter int  NUM_ELEMS = 3,
  localparam int W         = calc_w(QI, QF)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      s_valid,
  output logic                      s_ready,
  input  logic [W-1:0]              s_re,
  input  logic [W-1:0]              s_im,
  input  logic                      keep_kernel,
  output logic [6*W-1:0]            kernel,
  output logic [2*W*NUM_ELEMS-1:0]  signal,
  output logic                      conv_en,
  input  logic                      conv_done,
  input  logic                      conv_overflow,
  output logic                      frame_done,
  output logic                      frame_overflow
);

  localparam int TW = $clog2(NUM_TAPS);
  localparam int EW = (NUM_ELEMS > 1) ? $clog2(NUM_ELEMS) : 1;

  state_t        state, next_state;
  logic [TW-1:0] tap_cnt, tap_cnt_next;
  logic [EW-1:0] elem_cnt, elem_cnt_next;
  logic          k_loaded, k_loaded_next;
  logic          xfer, last_tap, last_elem;

  // s_ready depends on state only, so there is no path from s_valid.
  assign s_ready   = (state == LOAD_K) || (state == LOAD_S);
  assign xfer      = s_valid && s_ready;
  assign last_tap  = (tap_cnt == TW'(NUM_TAPS - 1));
  assign last_elem = (elem_cnt == EW'(NUM_ELEMS - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= LOAD_K;
      tap_cnt        <= '0;
      elem_cnt       <= '0;
      k_loaded       <= 1'b0;
      conv_en        <= 1'b0;
      frame_done     <= 1'b0;
      frame_overflow <= 1'b0;
    end else begin
      state      <= next_state;
      tap_cnt    <= tap_cnt_next;
      elem_cnt   <= elem_cnt_next;
      k_loaded   <= k_loaded_next;
      conv_en    <= (next_state == RUN) || (next_state == WAIT_DONE);
      frame_done <= (state == WAIT_DONE) && conv_done;
      if ((state == WAIT_DONE) && conv_done) begin
        frame_overflow <= conv_overflow;
      end
    end
  end

  // Counters hold only while staying in their own load state, so every entry starts at 0.
  always_comb begin
    next_state    = state;
    tap_cnt_next  = '0;
    elem_cnt_next = '0;
    k_loaded_next = k_loaded;
    case (state)
      LOAD_K: begin
        tap_cnt_next = tap_cnt;
        if (xfer) begin
          if (last_tap) begin
            next_state    = LOAD_S;
            tap_cnt_next  = '0;
            k_loaded_next = 1'b1;
          end else begin
            tap_cnt_next = tap_cnt + TW'(1);
          end
        end
      end
      LOAD_S: begin
        elem_cnt_next = elem_cnt;
        if (xfer) begin
          if (last_elem) begin
            next_state    = RUN;
            elem_cnt_next = '0;
          end else begin
            elem_cnt_next = elem_cnt + EW'(1);
          end
        end
      end
      RUN: begin
        next_state = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (conv_done) begin
          if (keep_kernel && k_loaded) begin
            next_state = LOAD_S;
          end else begin
            next_state    = LOAD_K;
            k_loaded_next = 1'b0;
          end
        end
      end
      default: begin
        next_state = LOAD_K;
      end
    endcase
  end

  cplx_pack_reg #(
    .W         (W),
    .N         (NUM_TAPS),
    .MSB_FIRST (1'b1),
    .IW        (TW)
  ) u_kernel_bank (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (xfer && (state == LOAD_K)),
    .wr_idx (tap_cnt),
    .re     (s_re),
    .im     (s_im),
    .data   (kernel)
  );

  cplx_pack_reg #(
    .W         (W),
    .N         (NUM_ELEMS),
    .MSB_FIRST (1'b0),
    .IW        (EW)
  ) u_signal_bank (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (xfer && (state == LOAD_S)),
    .wr_idx (elem_cnt),
    .re     (s_re),
    .im     (s_im),
    .data   (signal)
  );

endmodule

// File: tb/tb_conv_frame_loader.sv
// Scoreboard bench for conv_frame_loader: the stimulus queues expected frames and
// spot checks; a negedge monitor pops and compares them as the DUT presents outputs.
module tb_conv_frame_loader;

  localparam int QI = 4;
  localparam int QF = 4;
  localparam int NE = 3;
  localparam int W  = QI + QF;

  localparam int SEL_KERNEL  = 0;
  localparam int SEL_SIGNAL  = 1;
  localparam int SEL_EN      = 2;
  localparam int SEL_FDONE   = 3;
  localparam int SEL_FOVF    = 4;
  localparam int SEL_READY   = 5;
  localparam int SEL_TIMEOUT = 6;

  localparam logic [47:0] K_A = 48'h042012F000F4;
  localparam logic [47:0] S_A = 48'h11D0FA1428FC;
  localparam logic [47:0] S_B = 48'h050603040102;
  localparam logic [47:0] K_D = 48'h010102020303;
  localparam logic [47:0] S_D = 48'hEEFFCCDDAABB;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic [W-1:0]      s_re = '0;
  logic [W-1:0]      s_im = '0;
  logic              keep_kernel = 1'b0;
  logic [6*W-1:0]    kernel;
  logic [2*W*NE-1:0] signal;
  logic              conv_en;
  logic              conv_done = 1'b0;
  logic              conv_overflow = 1'b0;
  logic              frame_done;
  logic              frame_overflow;

  typedef struct {
    string       name;
    int          sel;
    logic [47:0] exp;
  } imm_t;

  typedef struct {
    logic [47:0] kern;
    logic [47:0] sig;
    logic        ovf;
  } frame_t;

  imm_t   imm_q[$];
  frame_t run_q[$];
  frame_t done_q[$];
  int     total = 0;
  int     bad = 0;
  bit     finish_req = 1'b0;
  logic   prev_en = 1'b0;
  logic   prev_fd = 1'b0;

  conv_frame_loader #(.QI(QI), .QF(QF), .NUM_ELEMS(NE)) dut (
    .clk            (clk),
    .rst            (rst),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_re           (s_re),
    .s_im           (s_im),
    .keep_kernel    (keep_kernel),
    .kernel         (kernel),
    .signal         (signal),
    .conv_en        (conv_en),
    .conv_done      (conv_done),
    .conv_overflow  (conv_overflow),
    .frame_done     (frame_done),
    .frame_overflow (frame_overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [47:0] actual(input int sel);
    case (sel)
      SEL_KERNEL: return kernel;
      SEL_SIGNAL: return signal;
      SEL_EN:     return {47'b0, conv_en};
      SEL_FDONE:  return {47'b0, frame_done};
      SEL_FOVF:   return {47'b0, frame_overflow};
      SEL_READY:  return {47'b0, s_ready};
      default:    return 48'd0;
    endcase
  endfunction

  task automatic compare(input string name, input logic [47:0] act, input logic [47:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // The monitor is the only process that compares and counts.
  initial begin
    forever begin
      @(negedge clk);
      while (imm_q.size() > 0) begin
        imm_t it;
        it = imm_q.pop_front();
        compare(it.name, actual(it.sel), it.exp);
      end
      compare("ready_vs_en", {47'b0, s_ready}, {47'b0, ~conv_en});
      if (conv_en && !prev_en) begin
        if (run_q.size() == 0) begin
          compare("run_unexpected", {47'b0, conv_en}, 48'd0);
        end else begin
          frame_t f;
          f = run_q.pop_front();
          compare("run_kernel", kernel, f.kern);
          compare("run_signal", signal, f.sig);
        end
      end
      if (frame_done) begin
        compare("fd_one_cycle", {47'b0, prev_fd}, 48'd0);
        if (done_q.size() == 0) begin
          compare("fd_unexpected", {47'b0, frame_done}, 48'd0);
        end else begin
          frame_t f;
          f = done_q.pop_front();
          compare("fd_overflow", {47'b0, frame_overflow}, {47'b0, f.ovf});
          compare("fd_kernel", kernel, f.kern);
          compare("fd_signal", signal, f.sig);
        end
      end
      prev_en = conv_en;
      prev_fd = frame_done;
      if (finish_req) begin
        compare("run_q_left", 48'(run_q.size()), 48'd0);
        compare("done_q_left", 48'(done_q.size()), 48'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  task automatic checkOutput(input string name, input int sel, input logic [47:0] exp);
    imm_t it;
    it.name = name;
    it.sel  = sel;
    it.exp  = exp;
    imm_q.push_back(it);
  endtask

  // One transfer, optionally preceded by random idle cycles; bounded wait on s_ready.
  task automatic applyStimulus(input logic [W-1:0] re, input logic [W-1:0] im, input bit gaps);
    bit ok;
    int tries;
    tries = 0;
    while (gaps && ($urandom_range(0, 1) == 1) && (tries < 8)) begin
      s_valid = 1'b0;
      s_re    = W'($urandom);
      s_im    = W'($urandom);
      @(posedge clk);
      #1;
      tries++;
    end
    s_valid = 1'b1;
    s_re    = re;
    s_im    = im;
    ok      = 1'b0;
    for (int i = 0; (i < 50) && !ok; i++) begin
      @(negedge clk);
      ok = s_ready;
      @(posedge clk);
      #1;
    end
    s_valid = 1'b0;
    if (!ok) checkOutput("xfer_timeout", SEL_TIMEOUT, 48'd1);
  endtask

  task automatic loadKernel(input logic [47:0] k, input bit gaps);
    for (int t = 0; t < 3; t++) begin
      applyStimulus(k[47-16*t -: 8], k[39-16*t -: 8], gaps);
    end
  endtask

  // Queues the expected packed words before the last element so the monitor sees them at RUN.
  task automatic loadSignal(input logic [47:0] k, input logic [47:0] s, input bit gaps);
    frame_t f;
    for (int e = 0; e < NE; e++) begin
      if (e == NE - 1) begin
        f.kern = k;
        f.sig  = s;
        f.ovf  = 1'b0;
        run_q.push_back(f);
      end
      applyStimulus(s[16*e+15 -: 8], s[16*e+7 -: 8], gaps);
    end
    checkOutput("en_after_load", SEL_EN, 48'd1);
  endtask

  // Waits with garbage on s_valid, then pulses conv_done and checks the flag holds afterwards.
  task automatic runFrame(input logic ovf, input logic keep, input int wait_cycles,
                          input logic [47:0] k, input logic [47:0] s);
    frame_t f;
    f.kern = k;
    f.sig  = s;
    f.ovf  = ovf;
    done_q.push_back(f);
    for (int i = 0; i < wait_cycles; i++) begin
      s_valid = 1'b1;
      s_re    = W'($urandom);
      s_im    = W'($urandom);
      @(posedge clk);
      #1;
    end
    s_valid       = 1'b0;
    conv_done     = 1'b1;
    conv_overflow = ovf;
    keep_kernel   = keep;
    @(posedge clk);
    #1;
    conv_done     = 1'b0;
    conv_overflow = 1'b0;
    keep_kernel   = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("fd_low_after", SEL_FDONE, 48'd0);
    checkOutput("ovf_hold", SEL_FOVF, {47'b0, ovf});
  endtask

  task automatic checkResetState();
    checkOutput("rst_kernel", SEL_KERNEL, 48'd0);
    checkOutput("rst_signal", SEL_SIGNAL, 48'd0);
    checkOutput("rst_en", SEL_EN, 48'd0);
    checkOutput("rst_fdone", SEL_FDONE, 48'd0);
    checkOutput("rst_fovf", SEL_FOVF, 48'd0);
    checkOutput("rst_ready", SEL_READY, 48'd1);
  endtask

  initial begin
    $display("[TB] start");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkResetState();
    rst = 1'b1;

    $display("[TB] frame A: full load, overflow, keep kernel");
    loadKernel(K_A, 1'b0);
    loadSignal(K_A, S_A, 1'b0);
    runFrame(1'b1, 1'b1, 5, K_A, S_A);

    $display("[TB] frame B: reused kernel, stray conv_done in LOAD_S");
    conv_done = 1'b1;
    @(posedge clk);
    #1;
    conv_done = 1'b0;
    checkOutput("stray_done_fd", SEL_FDONE, 48'd0);
    checkOutput("stray_done_ready", SEL_READY, 48'd1);
    applyStimulus(8'h01, 8'h02, 1'b0);
    applyStimulus(8'h03, 8'h04, 1'b0);
    checkOutput("b_en_after_two", SEL_EN, 48'd0);
    applyStimulus(8'h05, 8'h06, 1'b0);
    begin
      frame_t f;
      f.kern = K_A;
      f.sig  = S_B;
      f.ovf  = 1'b0;
      run_q.push_front(f);
    end
    checkOutput("b_en_after_three", SEL_EN, 48'd1);
    checkOutput("b_kernel_kept", SEL_KERNEL, K_A);
    runFrame(1'b0, 1'b0, 2, K_A, S_B);

    $display("[TB] frame C: random valid gaps");
    loadKernel(K_A, 1'b1);
    loadSignal(K_A, S_A, 1'b1);
    runFrame(1'b0, 1'b0, 3, K_A, S_A);

    $display("[TB] frame D: reset mid-load, keep_kernel ignored after reset");
    loadKernel(K_A, 1'b0);
    applyStimulus(8'h28, 8'hFC, 1'b0);
    applyStimulus(8'hFA, 8'h14, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checkResetState();
    rst = 1'b1;
    keep_kernel = 1'b1;
    loadKernel(K_D, 1'b0);
    checkOutput("d_en_after_taps", SEL_EN, 48'd0);
    loadSignal(K_D, S_D, 1'b0);
    runFrame(1'b1, 1'b0, 1, K_D, S_D);

    repeat (2) @(posedge clk);
    finish_req = 1'b1;
    repeat (20) @(posedge clk);
    $display("[TB] FAIL monitor_stall: got no summary expected summary");
    $fatal(1, "[TB] monitor did not finish");
  end

endmodule

// File: doc/conv_frame_loader.md
CONV_FRAME_LOADER -- requirements
Module: conv_frame_loader

Interface
REQ-001 Parameters SHALL be: QI, default 4, integer bits; QF, default 4, fractional bits; NUM_ELEMS, default 3, complex signal samples per frame; W = QI+QF (derived, not overridable).
REQ-002 Ports SHALL be exactly (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- s_valid  in  1  input sample valid.
- s_ready  out  1  loader can accept a sample.
- s_re  in  W  sample real part, two's complement QI.QF.
- s_im  in  W  sample imaginary part, two's complement QI.QF.
- keep_kernel  in  1  reuse the stored kernel for the next frame.
- kernel  out  6*W  three complex taps to conv_complex.
- signal  out  2*W*NUM_ELEMS  complex samples to conv_complex.
- conv_en  out  1  enable to conv_complex.
- conv_done  in  1  done from conv_complex.
- conv_overflow  in  1  overflow from conv_complex.
- frame_done  out  1  one-cycle pulse when a frame completes.
- frame_overflow  out  1  conv_overflow captured at frame completion.

Function
REQ-003 A transfer SHALL occur on a rising edge where s_valid=1 and s_ready=1; there is no other way to accept a sample.
REQ-004 The FSM SHALL have four states: LOAD_K, LOAD_S, RUN, WAIT_DONE.
REQ-005 In LOAD_K, s_ready=1; three transfers SHALL be accepted as taps 0,1,2; the third transfer moves the FSM to LOAD_S and sets internal flag k_loaded.
REQ-006 Kernel packing SHALL be tap t real at kernel[6W-1-2Wt -: W] and tap t imaginary at kernel[5W-1-2Wt -: W], so tap 0 occupies the MSBs.
REQ-007 In LOAD_S, s_ready=1; NUM_ELEMS transfers SHALL be accepted as elements 0..NUM_ELEMS-1; the last transfer moves the FSM to RUN.
REQ-008 Signal packing SHALL be element e real at signal[2We+2W-1 -: W] and element e imaginary at signal[2We+W-1 -: W], so element 0 occupies the LSBs.
REQ-009 s_ready SHALL be 0 in RUN and WAIT_DONE.
REQ-010 RUN SHALL last exactly one cycle with conv_en=1, then move to WAIT_DONE; conv_en SHALL be registered.
REQ-011 In WAIT_DONE, conv_en SHALL remain 1 until the first cycle in which conv_done=1 is sampled.
REQ-012 On that conv_done cycle, the next cycle SHALL show conv_en=0, frame_done=1 for exactly one cycle, and frame_overflow equal to conv_overflow sampled with conv_done.
REQ-013 frame_overflow SHALL hold its value until the next frame_done.
REQ-014 On leaving WAIT_DONE, the next state SHALL be LOAD_S if keep_kernel=1 and k_loaded=1, otherwise LOAD_K; keep_kernel SHALL be sampled only on the conv_done cycle.
REQ-015 A conv_done seen in LOAD_K or LOAD_S SHALL be ignored.
REQ-016 kernel and signal SHALL be stable from the LOAD_S->RUN transition until frame_done; a tap or element register SHALL change only on its own transfer.
REQ-017 Tap and element counters SHALL reset to 0 on every state entry and SHALL never wrap mid-state.
REQ-018 There SHALL be no combinational path from s_valid to s_ready.

Reset
REQ-019 While rst=0 at a clock edge: state=LOAD_K, counters=0, k_loaded=0, kernel=0, signal=0, conv_en=0, frame_done=0, frame_overflow=0; s_ready SHALL follow the state, so it is 1 after reset.
REQ-020 Reset asserted mid-frame SHALL discard partial loads and deassert conv_en on the following edge.

Structure
REQ-021 A shared package SHALL hold the state enumeration encoding, the tap count (3), and the W derivation helper, shared with conv_complex benches.
REQ-022 Packing SHALL use one sub-module, cplx_pack_reg, a parameterised indexed complex-word register bank instantiated twice (3 taps; NUM_ELEMS elements).

Verification
REQ-023 Reset then load taps (04,20),(12,F0),(00,F4) and elements (28,FC),(FA,14),(11,D0) -> kernel=0x042012F000F4, signal=0x11D0FA142 8FC written as 0x11D0FA1428FC, conv_en=1 on the cycle after the last transfer.
REQ-024 Hold conv_done=0 for 5 cycles, then pulse conv_done=1 with conv_overflow=1 -> conv_en=1 throughout, then frame_done=1 for one cycle with frame_overflow=1.
REQ-025 With keep_kernel=1 at conv_done, send 3 samples -> FSM enters RUN after exactly 3 transfers and kernel is unchanged (0x042012F000F4).
REQ-026 Toggle s_valid randomly at 50% during loading -> packed outputs are identical to REQ-023, and s_ready=0 in every RUN and WAIT_DONE cycle.
REQ-027 Assert rst=0 after 2 signal transfers, then set keep_kernel=1 for the next frame -> all outputs are 0, and the next frame requires a full 3-tap kernel load.
REQ-028 Pulse conv_done=1 while in LOAD_S -> no frame_done and no state change.
